// File: rtl/ethertype_filter.sv
// AXI-Stream EtherType filter: classifies each frame on its first beat and forwards or drops it.
// Forwarded beats leave through a two-entry skid buffer whose input ready is a register.
module ethertype_filter #(
    parameter int                        DATA_WIDTH  = 128,
    parameter int                        KEEP_WIDTH  = DATA_WIDTH / 8,
    parameter int                        USER_WIDTH  = 1,
    parameter int                        MATCH_COUNT = 4,
    parameter logic [16*MATCH_COUNT-1:0] MATCH_TYPES = {16'h0800, 16'h86DD, 16'h0806, 16'h8100},
    parameter bit                        DENY_MODE   = 1'b0,
    parameter int                        COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   filter_enable,
    input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]  s_axis_tkeep,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic                   s_axis_tlast,
    input  logic [USER_WIDTH-1:0]  s_axis_tuser,
    output logic [DATA_WIDTH-1:0]  m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]  m_axis_tkeep,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic [USER_WIDTH-1:0]  m_axis_tuser,
    output logic [COUNT_WIDTH-1:0] pass_count,
    output logic [COUNT_WIDTH-1:0] drop_count,
    output logic [COUNT_WIDTH-1:0] runt_count
);

    typedef enum logic [1:0] {ST_IDLE, ST_PASS, ST_DROP} state_t;

    state_t                 r_state, w_stateNext;
    logic                   r_ready, w_readyNext;
    logic                   r_outValid, w_outValidNext;
    logic                   r_tmpValid, w_tmpValidNext;
    logic [DATA_WIDTH-1:0]  r_outData, r_tmpData;
    logic [KEEP_WIDTH-1:0]  r_outKeep, r_tmpKeep;
    logic                   r_outLast, r_tmpLast;
    logic [USER_WIDTH-1:0]  r_outUser, r_tmpUser;
    logic [COUNT_WIDTH-1:0] r_passCount, r_dropCount, r_runtCount;

    logic        w_accept, w_runt, w_match, w_firstPass, w_fwd;
    logic        w_passDone, w_dropDone, w_runtDone;
    logic        w_loadOutFromIn, w_loadTmpFromIn, w_loadOutFromTmp;
    logic [15:0] w_etherType;

    assign w_accept    = s_axis_tvalid & r_ready;
    assign w_etherType = {s_axis_tdata[103:96], s_axis_tdata[111:104]};
    assign w_runt      = s_axis_tlast & ~s_axis_tkeep[13];
    assign w_firstPass = ~filter_enable | (w_match ^ DENY_MODE);

    always_comb begin
        w_match = 1'b0;
        for (int i = 0; i < MATCH_COUNT; i++) begin
            if (w_etherType == MATCH_TYPES[16*i +: 16]) w_match = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_stateNext;
    end

    // A single-beat frame is decided and completed in IDLE without leaving it.
    always_comb begin
        w_stateNext = r_state;
        w_fwd       = 1'b0;
        w_passDone  = 1'b0;
        w_dropDone  = 1'b0;
        w_runtDone  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_runt) begin
                        w_runtDone = 1'b1;
                    end else if (w_firstPass) begin
                        w_fwd      = 1'b1;
                        w_passDone = s_axis_tlast;
                        if (!s_axis_tlast) w_stateNext = ST_PASS;
                    end else begin
                        w_dropDone = s_axis_tlast;
                        if (!s_axis_tlast) w_stateNext = ST_DROP;
                    end
                end
            end
            ST_PASS: begin
                if (w_accept) begin
                    w_fwd      = 1'b1;
                    w_passDone = s_axis_tlast;
                    if (s_axis_tlast) w_stateNext = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (w_accept) begin
                    w_dropDone = s_axis_tlast;
                    if (s_axis_tlast) w_stateNext = ST_IDLE;
                end
            end
            default: w_stateNext = ST_IDLE;
        endcase
    end

    // Ready is registered, so the skid entry absorbs the beat accepted while a stall is seen.
    always_comb begin
        w_outValidNext   = r_outValid;
        w_tmpValidNext   = r_tmpValid;
        w_loadOutFromIn  = 1'b0;
        w_loadTmpFromIn  = 1'b0;
        w_loadOutFromTmp = 1'b0;
        w_readyNext      = m_axis_tready | (~r_tmpValid & (~r_outValid | ~w_fwd));
        if (r_ready) begin
            if (m_axis_tready | ~r_outValid) begin
                w_outValidNext  = w_fwd;
                w_loadOutFromIn = 1'b1;
            end else begin
                w_tmpValidNext  = w_fwd;
                w_loadTmpFromIn = 1'b1;
            end
        end else if (m_axis_tready) begin
            w_outValidNext   = r_tmpValid;
            w_tmpValidNext   = 1'b0;
            w_loadOutFromTmp = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ready    <= 1'b0;
            r_outValid <= 1'b0;
            r_tmpValid <= 1'b0;
        end else begin
            r_ready    <= w_readyNext;
            r_outValid <= w_outValidNext;
            r_tmpValid <= w_tmpValidNext;
        end
    end

    always_ff @(posedge clk) begin
        if (w_loadOutFromIn) begin
            r_outData <= s_axis_tdata;
            r_outKeep <= s_axis_tkeep;
            r_outLast <= s_axis_tlast;
            r_outUser <= s_axis_tuser;
        end else if (w_loadOutFromTmp) begin
            r_outData <= r_tmpData;
            r_outKeep <= r_tmpKeep;
            r_outLast <= r_tmpLast;
            r_outUser <= r_tmpUser;
        end
        if (w_loadTmpFromIn) begin
            r_tmpData <= s_axis_tdata;
            r_tmpKeep <= s_axis_tkeep;
            r_tmpLast <= s_axis_tlast;
            r_tmpUser <= s_axis_tuser;
        end
    end

    // Counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_passCount <= '0;
            r_dropCount <= '0;
            r_runtCount <= '0;
        end else begin
            if (w_passDone && r_passCount != '1) r_passCount <= r_passCount + COUNT_WIDTH'(1);
            if (w_dropDone && r_dropCount != '1) r_dropCount <= r_dropCount + COUNT_WIDTH'(1);
            if (w_runtDone && r_runtCount != '1) r_runtCount <= r_runtCount + COUNT_WIDTH'(1);
        end
    end

    assign s_axis_tready = r_ready;
    assign m_axis_tvalid = r_outValid;
    assign m_axis_tdata  = r_outData;
    assign m_axis_tkeep  = r_outKeep;
    assign m_axis_tlast  = r_outLast;
    assign m_axis_tuser  = r_outUser;
    assign pass_count    = r_passCount;
    assign drop_count    = r_dropCount;
    assign runt_count    = r_runtCount;

endmodule

// File: tb/tb_ethertype_filter.sv
// Self-checking bench for ethertype_filter: directed scenarios plus randomized frames and
// output stalls, checked against a frame-level reference model and an expected-beat queue.
module tb_ethertype_filter;

    localparam int DW = 128;
    localparam int KW = 16;
    localparam int CW = 2;
    localparam int CMAX = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          filter_enable;
    logic [DW-1:0] s_axis_tdata;
    logic [KW-1:0] s_axis_tkeep;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          s_axis_tlast;
    logic [0:0]    s_axis_tuser;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic [0:0]    m_axis_tuser;
    logic [CW-1:0] pass_count;
    logic [CW-1:0] drop_count;
    logic [CW-1:0] runt_count;

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic          user;
        int            acc;
    } beat_t;

    beat_t expQ[$];
    int    checks = 0;
    int    failures = 0;
    int    cycleCount = 0;
    int    expPass = 0;
    int    expDrop = 0;
    int    expRunt = 0;
    int    readyMode = 1;
    bit    latencyMode = 1'b0;

    ethertype_filter #(
        .DATA_WIDTH (DW),
        .KEEP_WIDTH (KW),
        .USER_WIDTH (1),
        .MATCH_COUNT(4),
        .MATCH_TYPES({16'h0800, 16'h86DD, 16'h0806, 16'h8100}),
        .DENY_MODE  (1'b0),
        .COUNT_WIDTH(CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .filter_enable(filter_enable),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tkeep (s_axis_tkeep),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_tuser (s_axis_tuser),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tkeep (m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tuser (m_axis_tuser),
        .pass_count   (pass_count),
        .drop_count   (drop_count),
        .runt_count   (runt_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string tag, input logic [159:0] observed, input logic [159:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Frame-level rule: runts never pass; otherwise pass when filtering is off or the type is listed.
    function automatic bit modelPass(input logic [15:0] et, input logic fe, input bit isRunt);
        if (isRunt) return 1'b0;
        if (!fe) return 1'b1;
        return (et inside {16'h0800, 16'h86DD, 16'h0806, 16'h8100});
    endfunction

    function automatic int satInc(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic checkCounts(input int p, input int d, input int r);
        checkOutput("passCount", 160'(pass_count), 160'(p));
        checkOutput("dropCount", 160'(drop_count), 160'(d));
        checkOutput("runtCount", 160'(runt_count), 160'(r));
    endtask

    // Sends one frame (or its first `cut` beats); starts right where the previous frame ended.
    task automatic applyStimulus(input logic [15:0] et, input int nBeats, input bit makeRunt,
                                 input bit feToggle, input int cut, output int stalls);
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          u;
        bit            passIt;
        bit            isRunt;
        int            wt;
        beat_t         bt;
        stalls = 0;
        passIt = 1'b0;
        isRunt = 1'b0;
        for (int b = 0; b < nBeats && b < cut; b++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            k = 16'hFFFF;
            if (b == 0) begin
                d[103:96]  = et[15:8];
                d[111:104] = et[7:0];
            end
            if (b == nBeats - 1) begin
                if (nBeats == 1) k = makeRunt ? 16'h0FFF : (16'hFFFF >> $urandom_range(0, 2));
                else             k = 16'hFFFF >> $urandom_range(0, 15);
            end
            u = 1'($urandom);
            s_axis_tdata  = d;
            s_axis_tkeep  = k;
            s_axis_tuser  = u;
            s_axis_tlast  = (b == nBeats - 1);
            s_axis_tvalid = 1'b1;
            if (b == 0) begin
                isRunt = (nBeats == 1) && !k[13];
                passIt = modelPass(et, filter_enable, isRunt);
            end
            if (b == 1 && feToggle) filter_enable = ~filter_enable;
            wt = 0;
            @(negedge clk);
            while (!s_axis_tready && wt < 200) begin
                stalls++;
                wt++;
                @(negedge clk);
            end
            if (!s_axis_tready) begin
                checkOutput("acceptTimeout", 160'(s_axis_tready), 160'(1));
            end else begin
                if (passIt) begin
                    bt.data = d;
                    bt.keep = k;
                    bt.last = (b == nBeats - 1);
                    bt.user = u;
                    bt.acc  = cycleCount + 1;
                    expQ.push_back(bt);
                end
                if (b == nBeats - 1) begin
                    if (isRunt)      expRunt = satInc(expRunt);
                    else if (passIt) expPass = satInc(expPass);
                    else             expDrop = satInc(expDrop);
                end
            end
            @(posedge clk);
            #1;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic drain();
        int wt;
        wt = 0;
        readyMode = 1;
        while (expQ.size() != 0 && wt < 500) begin
            @(negedge clk);
            wt++;
        end
        repeat (3) @(negedge clk);
        checkOutput("drainEmpty", 160'(expQ.size()), 160'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("rstValid", 160'(m_axis_tvalid), 160'(0));
        checkOutput("rstReady", 160'(s_axis_tready), 160'(0));
        checkCounts(0, 0, 0);
        expQ.delete();
        expPass = 0;
        expDrop = 0;
        expRunt = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("readyAfterRst", 160'(s_axis_tready), 160'(1));
        @(posedge clk);
        #1;
    endtask

    // Output-side ready driver; in random mode it also wiggles m_axis_tready mid-cycle
    // and requires s_axis_tready to stay put.
    initial begin
        logic sampledReady;
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                0:       m_axis_tready = 1'b0;
                1:       m_axis_tready = 1'b1;
                default: m_axis_tready = ($urandom_range(0, 2) != 0);
            endcase
            if (readyMode == 2) begin
                @(negedge clk);
                #1;
                sampledReady  = s_axis_tready;
                m_axis_tready = ~m_axis_tready;
                #1;
                checkOutput("readyNotComb", 160'(s_axis_tready), 160'(sampledReady));
                m_axis_tready = ~m_axis_tready;
            end
        end
    end

    // Output monitor: beat-exact comparison against the expected queue plus hold-under-stall.
    always @(negedge clk) begin : monitor
        beat_t         e;
        logic [145:0]  held;
        bit            holdPending;
        if (rst) begin
            holdPending = 1'b0;
        end else begin
            if (holdPending) begin
                checkOutput("holdValid", 160'(m_axis_tvalid), 160'(1));
                checkOutput("holdBeat", 160'({m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser}), 160'(held));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (expQ.size() == 0) begin
                    checkOutput("extraBeat", 160'(m_axis_tvalid), 160'(0));
                end else begin
                    e = expQ.pop_front();
                    checkOutput("outBeat", 160'({m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser}),
                                160'({e.data, e.keep, e.last, e.user}));
                    if (latencyMode) checkOutput("latency", 160'(cycleCount), 160'(e.acc));
                end
                holdPending = 1'b0;
            end else if (m_axis_tvalid) begin
                holdPending = 1'b1;
                held = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};
            end else begin
                holdPending = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          st;
        logic [15:0] et;
        int          nb;
        bit          rt;
        logic [15:0] types [4];
        types = '{16'h0800, 16'h86DD, 16'h0806, 16'h8100};
        rst = 1'b1;
        filter_enable = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = '0;
        readyMode = 1;
        @(posedge clk);
        #1;
        doReset();

        // Basic pass with one-cycle latency
        latencyMode = 1'b1;
        applyStimulus(16'h0800, 3, 1'b0, 1'b0, 99, st);
        drain();
        latencyMode = 1'b0;
        checkCounts(1, 0, 0);

        // Basic drop, input never stalls
        applyStimulus(16'h88CC, 4, 1'b0, 1'b0, 99, st);
        checkOutput("dropNoStall", 160'(st), 160'(0));
        drain();
        checkCounts(1, 1, 0);

        // Runt carrying a listed type is still discarded
        applyStimulus(16'h0800, 1, 1'b1, 1'b0, 99, st);
        drain();
        checkCounts(1, 1, 1);

        // Filter disabled, then toggled mid-frame in both directions
        filter_enable = 1'b0;
        applyStimulus(16'h1234, 3, 1'b0, 1'b0, 99, st);
        drain();
        checkCounts(2, 1, 1);
        filter_enable = 1'b1;
        applyStimulus(16'h1234, 3, 1'b0, 1'b1, 99, st);
        drain();
        checkCounts(2, 2, 1);
        applyStimulus(16'h1234, 3, 1'b0, 1'b1, 99, st);
        drain();
        checkCounts(3, 2, 1);
        filter_enable = 1'b1;

        // Back-to-back pass/drop/pass under random output stalls
        doReset();
        readyMode = 2;
        applyStimulus(16'h86DD, $urandom_range(2, 5), 1'b0, 1'b0, 99, st);
        applyStimulus(16'h1111, $urandom_range(2, 5), 1'b0, 1'b0, 99, st);
        applyStimulus(16'h0806, $urandom_range(2, 5), 1'b0, 1'b0, 99, st);
        drain();
        checkCounts(2, 1, 0);

        // Random frames against the model
        readyMode = 2;
        for (int f = 0; f < 24; f++) begin
            et = ($urandom_range(0, 1) == 1) ? types[$urandom_range(0, 3)] : 16'($urandom);
            nb = $urandom_range(1, 4);
            rt = (nb == 1) && ($urandom_range(0, 2) == 0);
            filter_enable = ($urandom_range(0, 3) != 0);
            applyStimulus(et, nb, rt, ($urandom_range(0, 4) == 0), 99, st);
        end
        drain();
        checkCounts(expPass, expDrop, expRunt);
        filter_enable = 1'b1;

        // Saturation of the 2-bit pass counter
        doReset();
        for (int f = 0; f < 5; f++) begin
            applyStimulus(16'h8100, 1 + (f % 2), 1'b0, 1'b0, 99, st);
        end
        drain();
        checkCounts(3, 0, 0);

        // Reset in the middle of a buffered frame, then a fresh frame start
        readyMode = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        applyStimulus(16'h0800, 4, 1'b0, 1'b0, 2, st);
        doReset();
        readyMode = 1;
        applyStimulus(16'h88CC, 1, 1'b0, 1'b0, 99, st);
        drain();
        checkCounts(0, 1, 0);
        applyStimulus(16'h0800, 2, 1'b0, 1'b0, 99, st);
        drain();
        checkCounts(1, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
